// File: rtl/note_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : note_scroller
//  Brief    : Fetches note symbols from the song ROM into a 5-slot on-screen
//             window, scrolls it left at a fixed tick rate, consumes hits on
//             slot 0 and flags misses and end of song.
//  Revision : 1.0 - initial release
// ============================================================================
module note_scroller #(
    parameter int TICK_DIV     = 833333,
    parameter int LANE_SPACING = 48,
    parameter int NUM_SLOTS    = 5,
    parameter int SONG_LEN     = 64,
    parameter int ADDR_W       = 6
) (
    input  logic                   CLOCK_50,
    input  logic                   reset_b,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   hit,
    input  logic [4:0]             song_sym,
    output logic [ADDR_W-1:0]      song_addr,
    output logic [5*NUM_SLOTS-1:0] drawstream,
    output logic [4:0]             target,
    output logic [8:0]             xoffset,
    output logic                   advance,
    output logic                   miss,
    output logic                   busy,
    output logic                   done
);

    localparam int c_DRAW_W  = 5 * NUM_SLOTS;
    localparam int c_TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_LOAD_W  = $clog2(NUM_SLOTS + 2);
    localparam int c_SHIFT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [c_TICK_W-1:0]  c_TICK_MAX   = c_TICK_W'(TICK_DIV - 1);
    localparam logic [8:0]           c_XOFF_MAX   = 9'(LANE_SPACING - 1);
    localparam logic [c_LOAD_W-1:0]  c_LOAD_LAST  = c_LOAD_W'(NUM_SLOTS + 1);
    localparam logic [c_SHIFT_W-1:0] c_DRAIN_LAST = c_SHIFT_W'(NUM_SLOTS - 1);
    localparam logic [ADDR_W-1:0]    c_LAST_IDX   = ADDR_W'(SONG_LEN - 1);
    localparam logic [ADDR_W-1:0]    c_PF_START   = ADDR_W'(NUM_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [c_DRAW_W-1:0]   r_draw;
    logic [8:0]            r_xoffset;
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     r_pf_idx;      // song index currently held in prefetch
    logic [4:0]            r_prefetch;
    logic                  r_fetch_pend;  // capture song_sym into prefetch this cycle
    logic [c_TICK_W-1:0]   r_tick;
    logic [c_LOAD_W-1:0]   r_load_cnt;
    logic [c_SHIFT_W-1:0]  r_shift_cnt;
    logic                  r_advance;
    logic                  r_miss;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_active;
    logic                  w_tick;
    logic                  w_shift;
    logic                  w_last_pf;
    logic                  w_drain_end;
    logic                  w_load_end;
    logic [4:0]            w_shift_in;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    // Scrolling only advances while playing and not paused; a shift is the
    // tick that finds the window already scrolled a full lane.
    assign w_active    = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !pause;
    assign w_tick      = w_active && (r_tick == c_TICK_MAX);
    assign w_shift     = w_tick && (r_xoffset == 9'd0);
    assign w_last_pf   = (r_pf_idx == c_LAST_IDX);
    assign w_drain_end = (r_shift_cnt == c_DRAIN_LAST);
    assign w_load_end  = (r_load_cnt == c_LOAD_LAST);
    assign w_shift_in  = (r_state == S_RUN) ? r_prefetch : 5'd0;
    assign w_busy_nxt  = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN) ||
                         (w_state_nxt == S_DRAIN);
    assign w_done_nxt  = (w_state_nxt == S_DONE);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)                    w_state_nxt = S_LOAD;
            S_LOAD:         if (w_load_end)               w_state_nxt = S_RUN;
            S_RUN:          if (w_shift && w_last_pf)     w_state_nxt = S_DRAIN;
            S_DRAIN:        if (w_shift && w_drain_end)   w_state_nxt = S_DONE;
            default:                                      w_state_nxt = S_IDLE;
        endcase
    end

    // Window, ROM addressing, tick/scroll counters and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge reset_b) begin
        if (!reset_b) begin
            r_draw       <= '0;
            r_xoffset    <= 9'd0;
            r_addr       <= '0;
            r_pf_idx     <= '0;
            r_prefetch   <= 5'd0;
            r_fetch_pend <= 1'b0;
            r_tick       <= '0;
            r_load_cnt   <= '0;
            r_shift_cnt  <= '0;
            r_advance    <= 1'b0;
            r_miss       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_advance    <= 1'b0;
            r_miss       <= 1'b0;
            r_fetch_pend <= 1'b0;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;

            // ROM data for the address presented at the shift edge lands one
            // cycle later, so the refill of prefetch trails the shift by one.
            if (r_fetch_pend) begin
                r_prefetch <= song_sym;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_draw     <= '0;
                        r_addr     <= '0;
                        r_load_cnt <= '0;
                        r_prefetch <= 5'd0;
                    end
                end

                S_LOAD: begin
                    r_load_cnt <= r_load_cnt + 1'b1;
                    // Load cycle n sees the ROM word for address n-1.
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        if (int'(r_load_cnt) == k + 1) begin
                            r_draw[5*k +: 5] <= song_sym;
                        end
                    end
                    if (w_load_end) begin
                        r_prefetch <= song_sym;
                        r_pf_idx   <= c_PF_START;
                        r_xoffset  <= c_XOFF_MAX;
                        r_tick     <= '0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end

                S_RUN, S_DRAIN: begin
                    if (w_active) begin
                        r_tick <= (r_tick == c_TICK_MAX) ? '0 : r_tick + 1'b1;
                        if (w_shift) begin
                            r_advance <= 1'b1;
                            r_miss    <= |r_draw[4:0];
                            r_draw    <= {w_shift_in, r_draw[c_DRAW_W-1:5]};
                            if (r_state == S_RUN) begin
                                r_xoffset <= c_XOFF_MAX;
                                if (w_last_pf) begin
                                    r_shift_cnt <= '0;
                                end else begin
                                    r_pf_idx     <= r_pf_idx + 1'b1;
                                    r_fetch_pend <= 1'b1;
                                    if (r_addr != c_LAST_IDX) begin
                                        r_addr <= r_addr + 1'b1;
                                    end
                                end
                            end else begin
                                r_shift_cnt <= r_shift_cnt + 1'b1;
                                r_xoffset   <= w_drain_end ? 9'd0 : c_XOFF_MAX;
                            end
                        end else begin
                            if (w_tick) begin
                                r_xoffset <= r_xoffset - 9'd1;
                            end
                            // A hit coinciding with a shift is dropped.
                            if (hit) begin
                                r_draw[4:0] <= 5'd0;
                            end
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    assign song_addr  = r_addr;
    assign drawstream = r_draw;
    assign target     = r_draw[4:0];
    assign xoffset    = r_xoffset;
    assign advance    = r_advance;
    assign miss       = r_miss;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire
